spell_mem_gpio: RTL and testbench

Memory-mapped GPIO controller for the spell core's data-memory bus. It is the parametrised successor of the single-port pin/direction/port block. It provides `NUM_PORTS` 8-bit ports and keeps the legacy register addresses for port 0. It adds input synchronisers, rising-edge interrupt flags with per-bit enables, and a registered `irq` output toward the core.

---
 rtl/spell_gpio_pkg.sv | 21 ++
 rtl/spell_gpio_sync.sv | 33 +++
 rtl/spell_mem_gpio.sv | 127 ++++++++++++
 tb/tb_spell_mem_gpio.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spell_gpio_pkg.sv
// rtl/spell_gpio_pkg.sv - register map constants and flag helper for the spell GPIO block
package spell_gpio_pkg;

    localparam logic [2:0] GPIO_PIN  = 3'd0;
    localparam logic [2:0] GPIO_DDR  = 3'd1;
    localparam logic [2:0] GPIO_PORT = 3'd2;
    localparam logic [2:0] GPIO_IEN  = 3'd3;
    localparam logic [2:0] GPIO_IFR  = 3'd4;

    localparam int GPIO_STRIDE = 8;

    localparam logic [7:0] GPIO_UNMAPPED = 8'hFF;

    // Flag update with write-1-to-clear; a same-cycle set beats the clear.
    function automatic logic [7:0] gpio_flag_next(input logic [7:0] flags,
                                                  input logic [7:0] clr,
                                                  input logic [7:0] set);
        return (flags & ~clr) | set;
    endfunction

endpackage

// File: rtl/spell_gpio_sync.sv
// rtl/spell_gpio_sync.sv - 8-bit input synchroniser with rising-edge detect
module spell_gpio_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    output logic [7:0] sync,
    output logic [7:0] rise
);

    logic [SYNC_STAGES-1:0][7:0] chain;
    logic [7:0]                  prev;
    logic [SYNC_STAGES:0]        fill;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
            prev  <= 8'h00;
            fill  <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], din};
            prev  <= chain[SYNC_STAGES-1];
            fill  <= {fill[SYNC_STAGES-1:0], 1'b1};
        end
    end

    // Edges are only trusted once both sync and prev hold post-reset samples,
    // so a pin held high through reset does not look like a 0->1 transition.
    assign sync = chain[SYNC_STAGES-1];
    assign rise = sync & ~prev & {8{fill[SYNC_STAGES]}};

endmodule

// File: rtl/spell_mem_gpio.sv
// rtl/spell_mem_gpio.sv - memory-mapped multi-port GPIO with edge interrupts
module spell_mem_gpio
    import spell_gpio_pkg::*;
#(
    parameter int         NUM_PORTS   = 2,
    parameter logic [7:0] BASE_ADDR   = 8'h36,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   select,
    input  logic [7:0]             addr,
    input  logic [7:0]             data_in,
    input  logic                   write,
    output logic [7:0]             data_out,
    output logic                   data_ready,
    input  logic [8*NUM_PORTS-1:0] io_in,
    output logic [8*NUM_PORTS-1:0] io_out,
    output logic [8*NUM_PORTS-1:0] io_oe,
    output logic                   irq
);

    logic [7:0]             off;
    logic                   in_range;
    logic [1:0]             port_idx;
    logic [2:0]             reg_idx;
    logic                   wr_cycle;
    logic                   past_write;
    logic [7:0]             rd_val;
    logic [8*NUM_PORTS-1:0] sync_all;
    logic [8*NUM_PORTS-1:0] ien_all;
    logic [8*NUM_PORTS-1:0] ifr_all;
    logic [NUM_PORTS-1:0]   pend;

    assign off      = addr - BASE_ADDR;
    assign in_range = off < 8'(GPIO_STRIDE * NUM_PORTS);
    assign port_idx = off[4:3];
    assign reg_idx  = off[2:0];
    assign wr_cycle = select & write;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        logic [7:0] sync_v;
        logic [7:0] rise_v;
        logic [7:0] ddr_r;
        logic [7:0] port_r;
        logic [7:0] ien_r;
        logic [7:0] ifr_r;
        logic [7:0] clr_v;
        logic       hit;

        spell_gpio_sync #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk (clk),
            .rst (rst),
            .din (io_in[p*8 +: 8]),
            .sync(sync_v),
            .rise(rise_v)
        );

        assign hit   = wr_cycle && in_range && (port_idx == 2'(p));
        assign clr_v = (hit && reg_idx == GPIO_IFR) ? data_in : 8'h00;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                ddr_r  <= 8'h00;
                port_r <= 8'h00;
                ien_r  <= 8'h00;
                ifr_r  <= 8'h00;
            end else begin
                if (hit && reg_idx == GPIO_DDR) begin
                    ddr_r <= data_in;
                end
                // PIN writes toggle PORT only on the first cycle of a burst.
                if (hit && reg_idx == GPIO_PORT) begin
                    port_r <= data_in;
                end else if (hit && reg_idx == GPIO_PIN && !past_write) begin
                    port_r <= port_r ^ data_in;
                end
                if (hit && reg_idx == GPIO_IEN) begin
                    ien_r <= data_in;
                end
                ifr_r <= gpio_flag_next(ifr_r, clr_v, rise_v);
            end
        end

        assign io_out[p*8 +: 8]   = port_r;
        assign io_oe[p*8 +: 8]    = ddr_r;
        assign sync_all[p*8 +: 8] = sync_v;
        assign ien_all[p*8 +: 8]  = ien_r;
        assign ifr_all[p*8 +: 8]  = ifr_r;
        assign pend[p]            = |(ifr_r & ien_r);
    end

    always_comb begin
        rd_val = GPIO_UNMAPPED;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (in_range && port_idx == 2'(p)) begin
                case (reg_idx)
                    GPIO_PIN:  rd_val = sync_all[p*8 +: 8];
                    GPIO_DDR:  rd_val = io_oe[p*8 +: 8];
                    GPIO_PORT: rd_val = io_out[p*8 +: 8];
                    GPIO_IEN:  rd_val = ien_all[p*8 +: 8];
                    GPIO_IFR:  rd_val = ifr_all[p*8 +: 8];
                    default:   rd_val = GPIO_UNMAPPED;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out   <= 8'h00;
            data_ready <= 1'b0;
            past_write <= 1'b0;
            irq        <= 1'b0;
        end else begin
            data_ready <= select;
            past_write <= wr_cycle;
            irq        <= |pend;
            if (select) begin
                data_out <= write ? 8'h00 : rd_val;
            end
        end
    end

endmodule

// File: tb/tb_spell_mem_gpio.sv
// tb/tb_spell_mem_gpio.sv - randomized and directed self-checking bench for spell_mem_gpio
module tb_spell_mem_gpio;

    localparam int         NP   = 2;
    localparam logic [7:0] BASE = 8'h36;
    localparam int         S    = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            select = 1'b0;
    logic            write = 1'b0;
    logic [7:0]      addr = 8'h00;
    logic [7:0]      data_in = 8'h00;
    logic [7:0]      data_out;
    logic            data_ready;
    logic [8*NP-1:0] io_in = '0;
    logic [8*NP-1:0] io_out;
    logic [8*NP-1:0] io_oe;
    logic            irq;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    spell_mem_gpio #(
        .NUM_PORTS  (NP),
        .BASE_ADDR  (BASE),
        .SYNC_STAGES(S)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .select    (select),
        .addr      (addr),
        .data_in   (data_in),
        .write     (write),
        .data_out  (data_out),
        .data_ready(data_ready),
        .io_in     (io_in),
        .io_out    (io_out),
        .io_oe     (io_oe),
        .irq       (irq)
    );

    // Reference model: register file plus the history of pad samples since reset.
    logic [7:0]      m_ddr [NP];
    logic [7:0]      m_port[NP];
    logic [7:0]      m_ien [NP];
    logic [7:0]      m_ifr [NP];
    logic [7:0]      m_dout;
    logic            m_rdy;
    logic            m_irq;
    logic            m_pw;
    logic [8*NP-1:0] hist[$];

    task automatic m_clear();
        for (int p = 0; p < NP; p++) begin
            m_ddr[p] = 8'h00; m_port[p] = 8'h00; m_ien[p] = 8'h00; m_ifr[p] = 8'h00;
        end
        m_dout = 8'h00; m_rdy = 1'b0; m_irq = 1'b0; m_pw = 1'b0;
        hist.delete();
    endtask

    function automatic logic [7:0] m_sample(int back, int p);
        logic [8*NP-1:0] h;
        if (hist.size() < back) return 8'h00;
        h = hist[hist.size() - back];
        return h[p*8 +: 8];
    endfunction

    function automatic logic [8*NP-1:0] m_vec_port();
        logic [8*NP-1:0] v;
        for (int p = 0; p < NP; p++) v[p*8 +: 8] = m_port[p];
        return v;
    endfunction

    function automatic logic [8*NP-1:0] m_vec_ddr();
        logic [8*NP-1:0] v;
        for (int p = 0; p < NP; p++) v[p*8 +: 8] = m_ddr[p];
        return v;
    endfunction

    task automatic set_bus(input logic s, input logic w, input logic [7:0] a, input logic [7:0] d);
        select = s; write = w; addr = a; data_in = d;
    endtask

    // One clock edge: advance the model from the inputs the DUT sees, then park at negedge.
    task automatic tick();
        int         off, r, hp;
        logic [7:0] rd;
        logic [7:0] rise[NP];
        logic       any;
        @(posedge clk);
        if (rst) begin
            m_clear();
        end else begin
            for (int p = 0; p < NP; p++) begin
                rise[p] = 8'h00;
                if (hist.size() >= S + 1) rise[p] = m_sample(S, p) & ~m_sample(S + 1, p);
            end
            any = 1'b0;
            for (int p = 0; p < NP; p++) any = any | (|(m_ifr[p] & m_ien[p]));
            off = (int'(addr) - int'(BASE) + 256) % 256;
            hp = -1; r = 0; rd = 8'hFF;
            if (off < 8 * NP) begin
                hp = off / 8; r = off % 8;
                case (r)
                    0: rd = m_sample(S, hp);
                    1: rd = m_ddr[hp];
                    2: rd = m_port[hp];
                    3: rd = m_ien[hp];
                    4: rd = m_ifr[hp];
                    default: rd = 8'hFF;
                endcase
            end
            if (select) m_dout = write ? 8'h00 : rd;
            m_rdy = select;
            if (select && write && hp >= 0) begin
                case (r)
                    0: if (!m_pw) m_port[hp] = m_port[hp] ^ data_in;
                    1: m_ddr[hp] = data_in;
                    2: m_port[hp] = data_in;
                    3: m_ien[hp] = data_in;
                    4: m_ifr[hp] = m_ifr[hp] & ~data_in;
                    default: ;
                endcase
            end
            for (int p = 0; p < NP; p++) m_ifr[p] = m_ifr[p] | rise[p];
            m_pw  = select && write;
            m_irq = any;
            hist.push_back(io_in);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        n_cmp++; if (data_out !== 8'h00) begin n_bad++; $display("FAIL reset_data_out got %h want 00", data_out); end
        n_cmp++; if (data_ready !== 1'b0) begin n_bad++; $display("FAIL reset_data_ready got %b want 0", data_ready); end
        n_cmp++; if (io_out !== '0) begin n_bad++; $display("FAIL reset_io_out got %h want 0", io_out); end
        n_cmp++; if (io_oe !== '0) begin n_bad++; $display("FAIL reset_io_oe got %h want 0", io_oe); end
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq got %b want 0", irq); end
        @(negedge clk);
        tick(); tick();
        rst = 1'b0;
        set_bus(0, 0, 8'h00, 8'h00);
        repeat (4) tick();
    endtask

    task automatic test_legacy();
        set_bus(1, 1, 8'h37, 8'hF0); tick();
        set_bus(1, 1, 8'h38, 8'hA5); tick();
        n_cmp++; if (io_oe[7:0] !== 8'hF0) begin n_bad++; $display("FAIL legacy_ddr got %h want F0", io_oe[7:0]); end
        n_cmp++; if (io_out[7:0] !== 8'hA5) begin n_bad++; $display("FAIL legacy_port got %h want A5", io_out[7:0]); end
        n_cmp++; if (data_out !== 8'h00 || data_ready !== 1'b1) begin n_bad++; $display("FAIL legacy_write_ack got %h/%b want 00/1", data_out, data_ready); end
        set_bus(1, 0, 8'h38, 8'h00); tick();
        n_cmp++; if (data_out !== 8'hA5) begin n_bad++; $display("FAIL legacy_read_port got %h want A5", data_out); end
        set_bus(1, 0, 8'h3D, 8'h00); tick();
        n_cmp++; if (data_out !== 8'hFF) begin n_bad++; $display("FAIL legacy_reserved got %h want FF", data_out); end
        set_bus(0, 0, 8'h38, 8'h00); tick();
        n_cmp++; if (data_ready !== 1'b0 || data_out !== 8'hFF) begin n_bad++; $display("FAIL legacy_idle_hold got %h/%b want FF/0", data_out, data_ready); end
    endtask

    task automatic test_toggle_burst();
        set_bus(1, 1, 8'h38, 8'h0F); tick();
        set_bus(0, 0, 8'h00, 8'h00); tick();
        set_bus(1, 1, 8'h36, 8'h01);
        repeat (3) tick();
        n_cmp++; if (io_out[7:0] !== 8'h0E) begin n_bad++; $display("FAIL burst_toggle_once got %h want 0E", io_out[7:0]); end
        set_bus(0, 0, 8'h00, 8'h00); tick();
        set_bus(1, 1, 8'h36, 8'h01); tick();
        n_cmp++; if (io_out[7:0] !== 8'h0F) begin n_bad++; $display("FAIL burst_retoggle got %h want 0F", io_out[7:0]); end
        set_bus(0, 0, 8'h00, 8'h00); tick();
    endtask

    task automatic test_multiport();
        set_bus(1, 1, BASE + 8'd10, 8'h3C); tick();
        n_cmp++; if (io_out !== 16'h3C0F) begin n_bad++; $display("FAIL mp_port1_write got %h want 3C0F", io_out); end
        set_bus(1, 0, BASE + 8'd9, 8'h00); tick();
        n_cmp++; if (data_out !== 8'h00) begin n_bad++; $display("FAIL mp_ddr1_read got %h want 00", data_out); end
        set_bus(1, 0, BASE + 8'd16, 8'h00); tick();
        n_cmp++; if (data_out !== 8'hFF) begin n_bad++; $display("FAIL mp_out_of_range got %h want FF", data_out); end
        set_bus(1, 1, BASE + 8'd16, 8'h55); tick();
        n_cmp++; if (io_out !== 16'h3C0F || io_oe !== 16'h00F0) begin n_bad++; $display("FAIL mp_oor_write got %h/%h want 3C0F/00F0", io_out, io_oe); end
        set_bus(0, 0, 8'h00, 8'h00); tick();
    endtask

    task automatic test_irq();
        set_bus(1, 1, BASE + 8'd11, 8'h04); tick();
        set_bus(0, 0, 8'h00, 8'h00); tick();
        io_in[10] = 1'b1;
        tick(); tick(); tick();
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_early got %b want 0", irq); end
        set_bus(1, 0, BASE + 8'd12, 8'h00); tick();
        n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL irq_assert got %b want 1", irq); end
        n_cmp++; if (data_out !== 8'h04) begin n_bad++; $display("FAIL irq_ifr_read got %h want 04", data_out); end
        set_bus(1, 1, BASE + 8'd12, 8'h04); tick();
        set_bus(0, 0, 8'h00, 8'h00); tick();
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_clear got %b want 0", irq); end
        io_in[10] = 1'b0;
        repeat (4) tick();
        set_bus(1, 0, BASE + 8'd12, 8'h00); tick();
        n_cmp++; if (data_out !== 8'h00 || irq !== 1'b0) begin n_bad++; $display("FAIL irq_fall_no_flag got %h/%b want 00/0", data_out, irq); end
        set_bus(0, 0, 8'h00, 8'h00); tick();
    endtask

    task automatic test_collision();
        io_in[0] = 1'b1;
        tick(); tick();
        set_bus(1, 1, BASE + 8'd4, 8'h01); tick();
        set_bus(1, 0, BASE + 8'd4, 8'h00); tick();
        n_cmp++; if (data_out[0] !== 1'b1) begin n_bad++; $display("FAIL collision_set_wins got %h want bit0=1", data_out); end
        set_bus(1, 1, BASE + 8'd4, 8'h01); tick();
        set_bus(1, 0, BASE + 8'd4, 8'h00); tick();
        n_cmp++; if (data_out !== 8'h00) begin n_bad++; $display("FAIL collision_w1c got %h want 00", data_out); end
        set_bus(0, 0, 8'h00, 8'h00); tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            set_bus(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 4),
                    8'($urandom_range(8'h30, 8'h50)), 8'($urandom));
            if ($urandom_range(0, 3) == 0) io_in = io_in ^ (8*NP)'($urandom & $urandom);
            tick();
            n_cmp++;
            if (data_out !== m_dout || data_ready !== m_rdy || irq !== m_irq ||
                io_out !== m_vec_port() || io_oe !== m_vec_ddr()) begin
                n_bad++;
                $display("FAIL random[%0d] got dout=%h rdy=%b irq=%b out=%h oe=%h want %h %b %b %h %h",
                         i, data_out, data_ready, irq, io_out, io_oe,
                         m_dout, m_rdy, m_irq, m_vec_port(), m_vec_ddr());
            end
        end
        set_bus(0, 0, 8'h00, 8'h00); tick();
    endtask

    task automatic test_async_reset();
        set_bus(1, 1, BASE + 8'd1, 8'hFF); tick();
        set_bus(1, 1, BASE + 8'd3, 8'hFF); tick();
        set_bus(0, 0, 8'h00, 8'h00);
        io_in = '0;
        repeat (4) tick();
        io_in = '1;
        repeat (5) tick();
        n_cmp++; if (irq !== 1'b1 || io_oe[7:0] !== 8'hFF) begin n_bad++; $display("FAIL areset_setup got irq=%b oe=%h want 1/FF", irq, io_oe[7:0]); end
        set_bus(1, 1, BASE, 8'h55); tick();
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (io_oe !== '0 || io_out !== '0 || irq !== 1'b0 || data_ready !== 1'b0 || data_out !== 8'h00) begin
            n_bad++;
            $display("FAIL areset_immediate got oe=%h out=%h irq=%b rdy=%b dout=%h want all 0",
                     io_oe, io_out, irq, data_ready, data_out);
        end
        @(negedge clk);
        tick(); tick();
        rst = 1'b0;
        set_bus(0, 0, 8'h00, 8'h00);
        repeat (8) tick();
        set_bus(1, 0, BASE + 8'd4, 8'h00); tick();
        n_cmp++; if (data_out !== 8'h00 || data_out !== m_dout) begin n_bad++; $display("FAIL areset_ifr0 got %h want 00", data_out); end
        set_bus(1, 0, BASE + 8'd12, 8'h00); tick();
        n_cmp++; if (data_out !== 8'h00 || irq !== 1'b0) begin n_bad++; $display("FAIL areset_ifr1 got %h/%b want 00/0", data_out, irq); end
        set_bus(1, 0, BASE, 8'h00); tick();
        n_cmp++; if (data_out !== 8'hFF) begin n_bad++; $display("FAIL areset_pin_high got %h want FF", data_out); end
        set_bus(0, 0, 8'h00, 8'h00); tick();
    endtask

    initial begin
        m_clear();
        test_reset();
        test_legacy();
        test_toggle_burst();
        test_multiport();
        test_irq();
        test_collision();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
